// File: rtl/max7219_display.sv
// Continuously refreshes a chain of MAX7219 7-segment controllers from the live frame bytes.
// Each transaction shifts one 16-bit word per device, MSB first, while cs is low.
//
// state   | meaning
// GAP     | cs high, waiting 2*CLK_DIV cycles before the next transaction
// LOW     | cs low, spi_clk low, dout holds the current bit
// HIGH    | cs low, spi_clk high, device samples dout
// TAIL    | cs low, spi_clk low for CLK_DIV cycles after the last bit
// mode INIT sends the five setup words; mode REFRESH cycles digits 1..8 forever.
module max7219_display #(
  parameter int NUM_CASCADES = 2,
  parameter int INTENSITY    = 1,
  parameter int CLK_DIV      = 4
) (
  input  logic                               sysclk,
  input  logic                               reset,
  input  logic [4*NUM_CASCADES-1:0][7:0]     frame,
  output logic                               spi_clk,
  output logic                               dout,
  output logic                               cs,
  output logic                               stop,
  output logic [10:1]                        pin
);

  localparam int SW = 16 * NUM_CASCADES;
  localparam int CW = $clog2(2 * CLK_DIV + 1);
  localparam int BW = $clog2(SW + 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LOAD  = BW'(SW - 1);

  typedef enum logic [1:0] {GAP, LOW, HIGH, TAIL} bus_t;
  typedef enum logic {ST_INIT, ST_REFRESH} mode_t;

  bus_t            bus;
  mode_t           mode;
  logic [CW-1:0]   cnt;
  logic [BW-1:0]   bit_cnt;
  logic [2:0]      cmd_idx;
  logic [2:0]      digit;
  logic [SW-2:0]   shreg;
  logic [15:0]     init_word;
  logic [SW-1:0]   load_data;
  logic [7:0]      byte_sel;
  logic [3:0]      nib;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h7E;
      4'h1: s = 7'h30;
      4'h2: s = 7'h6D;
      4'h3: s = 7'h79;
      4'h4: s = 7'h33;
      4'h5: s = 7'h5B;
      4'h6: s = 7'h5F;
      4'h7: s = 7'h70;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h7B;
      4'hA: s = 7'h77;
      4'hB: s = 7'h1F;
      4'hC: s = 7'h4E;
      4'hD: s = 7'h3D;
      4'hE: s = 7'h4F;
      default: s = 7'h47;
    endcase
    return s;
  endfunction

  always_comb begin
    case (cmd_idx)
      3'd0:    init_word = 16'h0C01;
      3'd1:    init_word = 16'h0F00;
      3'd2:    init_word = 16'h0900;
      3'd3:    init_word = 16'h0B07;
      default: init_word = {8'h0A, 4'h0, 4'(INTENSITY)};
    endcase
  end

  // digit holds d-1: bits [2:1] pick the byte, bit 0 picks the nibble (odd d -> low).
  always_comb begin
    load_data = '0;
    byte_sel  = '0;
    nib       = '0;
    for (int k = 0; k < NUM_CASCADES; k++) begin
      byte_sel = frame[4*k + 3 - int'(digit[2:1])];
      nib      = digit[0] ? byte_sel[7:4] : byte_sel[3:0];
      if (mode == ST_INIT)
        load_data[16*k +: 16] = init_word;
      else
        load_data[16*k +: 16] = {4'h0, 4'({1'b0, digit}) + 4'd1, 1'b0, seg7(nib)};
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      bus     <= GAP;
      mode    <= ST_INIT;
      cnt     <= GAP_LOAD;
      bit_cnt <= '0;
      cmd_idx <= '0;
      digit   <= '0;
      shreg   <= '0;
      spi_clk <= 1'b0;
      dout    <= 1'b0;
      cs      <= 1'b1;
      stop    <= 1'b0;
    end else begin
      case (bus)
        GAP: begin
          if (cnt == '0) begin
            cs      <= 1'b0;
            dout    <= load_data[SW-1];
            shreg   <= load_data[SW-2:0];
            bit_cnt <= BIT_LOAD;
            cnt     <= HALF_LOAD;
            bus     <= LOW;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        LOW: begin
          if (cnt == '0) begin
            spi_clk <= 1'b1;
            cnt     <= HALF_LOAD;
            bus     <= HIGH;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HIGH: begin
          if (cnt == '0) begin
            spi_clk <= 1'b0;
            cnt     <= HALF_LOAD;
            if (bit_cnt == '0) begin
              bus <= TAIL;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
              dout    <= shreg[SW-2];
              shreg   <= {shreg[SW-3:0], 1'b0};
              bus     <= LOW;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        TAIL: begin
          if (cnt == '0) begin
            cs   <= 1'b1;
            dout <= 1'b0;
            cnt  <= GAP_LOAD;
            bus  <= GAP;
            if (mode == ST_INIT) begin
              if (cmd_idx == 3'd4) begin
                mode  <= ST_REFRESH;
                stop  <= 1'b1;
                digit <= '0;
              end else begin
                cmd_idx <= cmd_idx + 1'b1;
              end
            end else begin
              digit <= digit + 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: bus <= GAP;
      endcase
    end
  end

  assign pin = {6'b0, stop, dout, spi_clk, cs};

endmodule

// File: tb/tb_max7219_display.sv
// Directed bench for max7219_display (N=2, CLK_DIV=2, INTENSITY=1).
// Decodes each cs-low window into a 32-bit stream and compares against hand-computed words.
module tb_max7219_display;

  localparam int N = 2;
  localparam int D = 2;

  logic                 sysclk = 1'b0;
  logic                 reset  = 1'b1;
  logic [4*N-1:0][7:0]  frame;
  logic                 spi_clk, dout, cs, stop;
  logic [10:1]          pin;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   dout_glitches = 0;
  logic prev_dout = 1'b0;

  max7219_display #(.NUM_CASCADES(N), .INTENSITY(1), .CLK_DIV(D)) dut (
    .sysclk  (sysclk),
    .reset   (reset),
    .frame   (frame),
    .spi_clk (spi_clk),
    .dout    (dout),
    .cs      (cs),
    .stop    (stop),
    .pin     (pin)
  );

  always #5 sysclk = ~sysclk;

  // dout must never change on an edge that leaves spi_clk high
  always @(negedge sysclk) begin
    if (spi_clk === 1'b1 && dout !== prev_dout) dout_glitches++;
    prev_dout = dout;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns cs-high samples before the fall, cs-low length and decoded bits.
  task automatic get_stream(output logic [31:0] w, output int gap, output int low, output int rises);
    logic prev_clk;
    w = '0; gap = 0; low = 0; rises = 0; prev_clk = 1'b0;
    while (cs !== 1'b0 && gap < 1000) begin
      gap++;
      @(negedge sysclk);
    end
    if (gap >= 1000) chk("cs_fall_timeout", 64'(gap), 64'd0);
    while (cs === 1'b0 && low < 1000) begin
      low++;
      if (spi_clk && !prev_clk) begin
        w = {w[30:0], dout};
        rises++;
      end
      prev_clk = spi_clk;
      @(negedge sysclk);
    end
    if (low >= 1000) chk("cs_rise_timeout", 64'(low), 64'd0);
  endtask

  logic [31:0] init_exp [5];
  logic [31:0] ref_exp  [8];
  logic [31:0] w;
  int gap, low, rises;

  initial begin
    init_exp = '{32'h0C01_0C01, 32'h0F00_0F00, 32'h0900_0900, 32'h0B07_0B07, 32'h0A01_0A01};
    ref_exp  = '{32'h0147_017F, 32'h024F_0270, 32'h034F_035F, 32'h043D_045B,
                 32'h054E_0533, 32'h061F_0679, 32'h0777_076D, 32'h087B_0830};
    frame[0] = 8'h12; frame[1] = 8'h34; frame[2] = 8'h56; frame[3] = 8'h78;
    frame[4] = 8'h9A; frame[5] = 8'hBC; frame[6] = 8'hDE; frame[7] = 8'hEF;

    reset = 1'b1;
    repeat (5) @(negedge sysclk);
    chk("rst_spi_clk", 64'(spi_clk), 64'd0);
    chk("rst_dout",    64'(dout),    64'd0);
    chk("rst_cs",      64'(cs),      64'd1);
    chk("rst_stop",    64'(stop),    64'd0);
    chk("rst_pin",     64'(pin),     64'h001);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      get_stream(w, gap, low, rises);
      chk($sformatf("init_word%0d", i), 64'(w), 64'(init_exp[i]));
      if (i == 0) begin
        chk("first_fall_delay", 64'(gap), 64'(2*D));
        chk("cs_low_len",       64'(low), 64'((32*N+1)*D));
        chk("clk_rises",        64'(rises), 64'(16*N));
      end
      if (i == 1) chk("cs_high_gap", 64'(gap), 64'(2*D));
      if (i == 3) chk("stop_before_init_end", 64'(stop), 64'd0);
    end
    chk("stop_after_init", 64'(stop), 64'd1);
    chk("pin_idle_refresh", 64'(pin), 64'h009);

    for (int d = 0; d < 8; d++) begin
      get_stream(w, gap, low, rises);
      chk($sformatf("refresh_d%0d", d+1), 64'(w), 64'(ref_exp[d]));
      if (d == 0) begin
        chk("refresh_rises", 64'(rises), 64'(16*N));
        chk("refresh_gap",   64'(gap),   64'(2*D));
      end
    end

    // digit wrap, with frame[3] cleared while the d=1 word is on the wire
    fork
      get_stream(w, gap, low, rises);
      begin
        for (int k = 0; k < 1000 && cs !== 1'b0; k++) @(negedge sysclk);
        repeat (20) @(negedge sysclk);
        frame[3] = 8'h00;
      end
    join
    chk("wrap_d1_inflight", 64'(w), 64'h0147_017F);
    for (int d = 1; d < 8; d++) begin
      get_stream(w, gap, low, rises);
      if (d == 1) chk("refresh_d2_new", 64'(w), 64'h024F_027E);
      else        chk($sformatf("refresh2_d%0d", d+1), 64'(w), 64'(ref_exp[d]));
    end
    get_stream(w, gap, low, rises);
    chk("d1_after_change", 64'(w), 64'h0147_017E);

    // reset in the middle of a refresh transaction
    begin
      int  r, k;
      logic pc;
      r = 0; k = 0; pc = 1'b0;
      while (cs !== 1'b0 && k < 1000) begin k++; @(negedge sysclk); end
      while (r < 10 && k < 2000) begin
        k++;
        if (spi_clk && !pc) r++;
        pc = spi_clk;
        if (r < 10) @(negedge sysclk);
      end
      chk("mid_stop_before", 64'(stop), 64'd1);
      reset = 1'b1;
      @(negedge sysclk);
      chk("mid_rst_cs",      64'(cs),      64'd1);
      chk("mid_rst_spi_clk", 64'(spi_clk), 64'd0);
      chk("mid_rst_dout",    64'(dout),    64'd0);
      chk("mid_rst_stop",    64'(stop),    64'd0);
      reset = 1'b0;
    end
    get_stream(w, gap, low, rises);
    chk("restart_gap",  64'(gap), 64'(2*D));
    chk("restart_word", 64'(w),   64'h0C01_0C01);

    chk("dout_stable_high", 64'(dout_glitches), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
